// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM state encoding,
// default parameter values and the phase-timer width helper.
package pulse_train_gen_pkg;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_WINDOW_BITS = 12;
  localparam int unsigned DEF_HIGH_CYCLES = 4;
  localparam int unsigned DEF_LOW_CYCLES  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_DONE
  } state_e;

  // The phase timer is loaded with (cycles - 1), so it needs to hold values
  // up to max(high, low) - 1; never narrower than one bit.
  function automatic int unsigned phase_bits(input int unsigned high_cycles,
                                             input int unsigned low_cycles);
    int unsigned m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter used to time the HIGH and LOW phases of each pulse.
// A load takes priority; otherwise the count decrements until it reaches zero
// and then rests there with zero_o asserted.
module phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, else count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Frame-based pulse train generator. An accepted start opens a window of
// 2^WINDOW_BITS cycles during which up to count_in pulses (HIGH_CYCLES high,
// LOW_CYCLES low) are emitted; pulses still in flight when the window closes
// are cut short. A one-cycle done strobe closes every frame.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned WINDOW_BITS = DEF_WINDOW_BITS,
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] count_in,
  output logic             pulse_out,
  output logic             ready,
  output logic             running,
  output logic             done,
  output logic [WIDTH-1:0] pulses_sent
);

  localparam int unsigned      PT_W   = phase_bits(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [PT_W-1:0]  H_LOAD = PT_W'(HIGH_CYCLES - 1);
  localparam logic [PT_W-1:0]  L_LOAD = PT_W'(LOW_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [WINDOW_BITS-1:0] win_q, win_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       sent_q, sent_d;
  logic                   pulse_q, ready_q, running_q, done_q;

  logic                   ph_load;
  logic [PT_W-1:0]        ph_load_val;
  logic                   ph_zero;
  logic                   win_last;

  phase_timer #(
    .CNT_W (PT_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ph_load),
    .load_val_i (ph_load_val),
    .zero_o     (ph_zero)
  );

  assign win_last = (win_q == '1);

  // Next-state, window/remaining/tally counters and phase-timer loads.
  // Window expiry is checked before phase completion in HIGH so a truncated
  // pulse goes straight to DONE; in LOW a phase that completes on the last
  // window cycle is still counted as a full pulse.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    rem_d       = rem_q;
    sent_d      = sent_q;
    ph_load     = 1'b0;
    ph_load_val = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d  = count_in;
          sent_d = '0;
          win_d  = '0;
          if (count_in != '0) begin
            state_d     = S_HIGH;
            ph_load     = 1'b1;
            ph_load_val = H_LOAD;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HIGH: begin
        win_d = win_q + 1'b1;
        if (win_last) begin
          state_d = S_DONE;
        end else if (ph_zero) begin
          state_d     = S_LOW;
          ph_load     = 1'b1;
          ph_load_val = L_LOAD;
        end
      end
      S_LOW: begin
        win_d = win_q + 1'b1;
        if (ph_zero) begin
          sent_d = sent_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (win_last) begin
            state_d = S_DONE;
          end else if (rem_q > WIDTH'(1)) begin
            state_d     = S_HIGH;
            ph_load     = 1'b1;
            ph_load_val = H_LOAD;
          end else begin
            state_d = S_HOLD;
          end
        end else if (win_last) begin
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        win_d = win_q + 1'b1;
        if (win_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs (outputs decoded from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      rem_q     <= '0;
      sent_q    <= '0;
      pulse_q   <= 1'b0;
      ready_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rem_q     <= rem_d;
      sent_q    <= sent_d;
      pulse_q   <= (state_d == S_HIGH);
      ready_q   <= (state_d == S_IDLE);
      running_q <= (state_d == S_HIGH) || (state_d == S_LOW) || (state_d == S_HOLD);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign pulse_out   = pulse_q;
  assign ready       = ready_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: two instances (long window H=L=2, short window
// H=L=4) checked cycle by cycle against an arithmetic frame model.
module tb_pulse_train_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, pulse_a, ready_a, running_a, done_a;
  logic [7:0] count_a, sent_a;
  logic       rst_b, start_b, pulse_b, ready_b, running_b, done_b;
  logic [7:0] count_b, sent_b;

  int total = 0;
  int bad   = 0;

  localparam int N_A = 4096, P_A = 4, H_A = 2;
  localparam int N_B = 64,   P_B = 8, H_B = 4;

  pulse_train_gen #(
    .WIDTH(8), .WINDOW_BITS(12), .HIGH_CYCLES(2), .LOW_CYCLES(2)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .count_in(count_a),
    .pulse_out(pulse_a), .ready(ready_a), .running(running_a),
    .done(done_a), .pulses_sent(sent_a)
  );

  pulse_train_gen #(
    .WIDTH(8), .WINDOW_BITS(6), .HIGH_CYCLES(4), .LOW_CYCLES(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .count_in(count_b),
    .pulse_out(pulse_b), .ready(ready_b), .running(running_b),
    .done(done_b), .pulses_sent(sent_b)
  );

  typedef struct {
    int n;
    int exp_sent;
    int exp_edges;
  } vec_t;

  // Packed observation: {pulse_out, ready, running, done, pulses_sent}
  function automatic logic [11:0] obs(input bit b);
    if (b) return {pulse_b, ready_b, running_b, done_b, sent_b};
    else   return {pulse_a, ready_a, running_a, done_a, sent_a};
  endfunction

  // Expected outputs in cycle k after acceptance (k=1 is first window cycle).
  function automatic logic [11:0] model(input int k, input int n, input int nw,
                                        input int p, input int h);
    int  idx, s;
    logic pl, rd, rn, dn;
    if (k <= nw) begin
      idx = (k - 1) / p;
      pl  = (idx < n) && (((k - 1) % p) < h);
      rd  = 1'b0; rn = 1'b1; dn = 1'b0;
      s   = (idx < n) ? idx : n;
    end else begin
      pl = 1'b0; rn = 1'b0;
      dn = (k == nw + 1);
      rd = (k == nw + 2);
      s  = ((nw / p) < n) ? (nw / p) : n;
    end
    return {pl, rd, rn, dn, 8'(s)};
  endfunction

  task automatic chk(input string nm, input int k, input logic [11:0] act,
                     input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got={p,rdy,run,dn,sent}=%h want=%h", nm, k, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit b, input logic s, input logic [7:0] c);
    if (b) begin start_b = s; count_b = c; end
    else   begin start_a = s; count_a = c; end
  endtask

  // Called #1 after a posedge with the DUT idle; returns the same way.
  task automatic run_frame(input bit b, input int n, input bit noise,
                           output int sent_end, output int n_edges);
    int   nw, p, h;
    logic prev, cur;
    string nm;
    nw = b ? N_B : N_A;
    p  = b ? P_B : P_A;
    h  = b ? H_B : H_A;
    nm = b ? "frame_b" : "frame_a";
    set_in(b, 1'b1, 8'(n));
    @(posedge clk); #1;
    set_in(b, 1'b0, 8'($urandom));
    prev = 1'b0; n_edges = 0; sent_end = -1;
    for (int k = 1; k <= nw + 2; k++) begin
      chk(nm, k, obs(b), model(k, n, nw, p, h));
      cur = obs(b)[11];
      if (cur && !prev) n_edges++;
      prev = cur;
      if (k == nw + 2) sent_end = int'(obs(b)[7:0]);
      if (noise) set_in(b, (k <= nw + 1) && ($urandom_range(0, 5) == 0), 8'($urandom));
      @(posedge clk); #1;
    end
    set_in(b, 1'b0, 8'($urandom));
  endtask

  vec_t vecs[7];
  int   se, ne;

  initial begin
    vecs[0] = '{0,   0, 0};
    vecs[1] = '{1,   1, 1};
    vecs[2] = '{3,   3, 3};
    vecs[3] = '{8,   8, 8};
    vecs[4] = '{9,   8, 8};
    vecs[5] = '{20,  8, 8};
    vecs[6] = '{255, 8, 8};

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    count_a = '0; count_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 0, obs(0), 12'h400);
    chk("reset_b", 0, obs(1), 12'h400);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("idle_a", 0, obs(0), 12'h400);
    chk("idle_b", 0, obs(1), 12'h400);

    // Nominal long frame: 3 pulses, done at cycle 4097, ready at 4098.
    run_frame(0, 3, 1'b0, se, ne);
    chk_int("nominal_sent", se, 3);
    chk_int("nominal_edges", ne, 3);

    // Zero-count long frame with ignored start pulses.
    run_frame(0, 0, 1'b1, se, ne);
    chk_int("zero_sent", se, 0);
    chk_int("zero_edges", ne, 0);

    // Table on the short window (truncation at 8 pulses).
    foreach (vecs[i]) begin
      run_frame(1, vecs[i].n, 1'b1, se, ne);
      chk_int($sformatf("tbl%0d_sent", i), se, vecs[i].exp_sent);
      chk_int($sformatf("tbl%0d_edges", i), ne, vecs[i].exp_edges);
    end

    // Busy start: frame of 2, then make sure nothing restarts.
    run_frame(1, 2, 1'b1, se, ne);
    chk_int("busy_sent", se, 2);
    chk_int("busy_edges", ne, 2);
    for (int k = 0; k < 70; k++) begin
      chk("busy_idle", k, obs(1), 12'h402);
      @(posedge clk); #1;
    end

    // Randomized frames.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = int'($urandom_range(0, 12));
      run_frame(1, n, 1'b1, se, ne);
      chk_int($sformatf("rnd%0d_edges", r), ne, (n < 8) ? n : 8);
    end

    // Reset during HIGH of pulse 2 (cycle 9 on the short window).
    set_in(1, 1'b1, 8'd3);
    @(posedge clk); #1;
    set_in(1, 1'b0, 8'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_pulse", 9, obs(1), model(9, 3, N_B, P_B, H_B));
    #2 rst_b = 1'b1;
    #1 chk("rst_async", 9, obs(1), 12'h400);
    @(posedge clk); #1;
    rst_b = 1'b0;
    for (int k = 0; k < 80; k++) begin
      chk("post_rst", k, obs(1), 12'h400);
      @(posedge clk); #1;
    end
    run_frame(1, 2, 1'b0, se, ne);
    chk_int("after_rst_sent", se, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of the pulse-count request and of the sent-pulse tally.
REQ-002 SHALL have parameter WINDOW_BITS, default 12, so the frame window is 2^WINDOW_BITS clk cycles.
REQ-003 SHALL have parameter HIGH_CYCLES, default 4, pulse high time in clk cycles (>=1).
REQ-004 SHALL have parameter LOW_CYCLES, default 4, pulse low time in clk cycles (>=1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, frame request, sampled only in IDLE.
REQ-008 SHALL have port count_in, input, WIDTH, number of pulses to emit, latched on an accepted start.
REQ-009 SHALL have port pulse_out, output, 1, registered pulse train.
REQ-010 SHALL have port ready, output, 1, high only in IDLE.
REQ-011 SHALL have port running, output, 1, high for the whole frame window.
REQ-012 SHALL have port done, output, 1, single-cycle end-of-frame strobe.
REQ-013 SHALL have port pulses_sent, output, WIDTH, count of complete pulses emitted in the current or last frame.

Function
REQ-014 SHALL implement states IDLE, HIGH, LOW, HOLD, DONE.
REQ-015 SHALL accept start when start=1 in IDLE at edge T: latch count_in, clear the window counter, clear pulses_sent, and leave IDLE at T+1.
REQ-016 SHALL go from IDLE to HIGH when the latched count >0, and to HOLD when it =0.
REQ-017 SHALL drive pulse_out=1 exactly in HIGH, starting the cycle after start acceptance.
REQ-018 SHALL stay in HIGH for HIGH_CYCLES cycles, then go to LOW.
REQ-019 SHALL stay in LOW for LOW_CYCLES cycles, then increment pulses_sent and decrement the remaining count.
REQ-020 SHALL, at the end of LOW, go to HIGH if remaining >0, else to HOLD.
REQ-021 SHALL hold pulse_out=0 in HOLD until the window counter reaches 2^WINDOW_BITS-1.
REQ-022 SHALL keep running=1 in HIGH, LOW and HOLD, for exactly 2^WINDOW_BITS cycles per frame.
REQ-023 SHALL, when the window expires in HIGH or LOW (truncation), go directly to DONE.
REQ-024 On truncation, pulse_out SHALL drop at the same edge, and pulses_sent SHALL count only pulses whose LOW phase completed.
REQ-025 In DONE, SHALL assert done=1 for one cycle, then go to IDLE; ready=1 in the following cycle.
REQ-026 SHALL ignore start while not in IDLE; count_in changes outside the accept cycle SHALL have no effect.
REQ-027 SHALL keep pulses_sent saturated arithmetic-free: it never exceeds the latched count, so no wrap occurs.
REQ-028 SHALL hold pulses_sent stable from DONE until the next accepted start.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE; pulse_out=0, running=0, done=0, pulses_sent=0, ready=1; all internal counters 0.
REQ-030 Reset mid-frame SHALL abort the frame with no done strobe; the first start after reset release SHALL behave as REQ-015.

Structure
REQ-031 The shared package SHALL hold the state enum and the default constants for WIDTH, WINDOW_BITS, HIGH_CYCLES and LOW_CYCLES.
REQ-032 The phase timing (HIGH/LOW cycle countdown) SHALL be one sub-module, phase_timer, loadable down-counter with a zero flag.
REQ-033 The window counter and the remaining/pulses_sent counters SHALL live in pulse_train_gen.

Verification
REQ-034 Nominal: count_in=3, H=L=2, start at cycle 0 -> pulse_out high in cycles 1-2, 5-6, 9-10; pulses_sent=3; done in cycle 4097; ready in cycle 4098.
REQ-035 Zero count: count_in=0 -> pulse_out stays 0; running high 4096 cycles; done once; pulses_sent=0.
REQ-036 Truncation: WINDOW_BITS=6, H=L=4, count_in=20 -> 8 full pulses, running 64 cycles, pulses_sent=8, pulse_out=0 after expiry.
REQ-037 Busy start: start pulsed with count_in=9 during a count_in=2 frame -> exactly 2 pulses; no second frame starts.
REQ-038 Reset mid-pulse: rst in HIGH of pulse 2 -> pulse_out, running=0 immediately; done never asserted; ready=1.
REQ-039 Loopback: pulse_out into the time-to-digital receiver data_in, count_in=5, H=L=8, shared start -> receiver count_out=5 at frame end.
